// File: rtl/dsp_avg_pkg.sv
// Shared definitions for the windowed moving-average blocks.
//   MAX_LOG2_WIN : largest supported log2 window length.
//   sum_width()  : accumulator width. It holds WIN full-scale samples without overflow.
// win_moving_avg stops elaboration with an error if LOG2_WIN is outside 1..MAX_LOG2_WIN.
package dsp_avg_pkg;

  localparam int unsigned MAX_LOG2_WIN = 6;

  function automatic int unsigned sum_width(input int unsigned data_width,
                                            input int unsigned log2_win);
    return data_width + log2_win;
  endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Fixed-depth shift register with no reset. This lets it map onto SRL primitives.
//   clock    : rising-edge clock
//   shift_en : push din and advance every entry by one
//   din      : word to push
//   dout     : tap DEPTH-1. It holds the word pushed DEPTH shifts before the next shift.
module sample_delay_line #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clock,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clock) begin
    if (shift_en) begin
      taps[0] <= din;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        taps[k] <= taps[k-1];
      end
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/win_moving_avg.sv
// Windowed moving average of complex I/Q samples over WIN = 2**LOG2_WIN accepted samples.
//   clock, reset_n   : clock; asynchronous active-low reset of all control and accumulator state
//   enable           : global qualifier; when low, all state holds
//   clear            : synchronous window restart; the fill count and the sums return to 0
//   in_i, in_q       : signed input sample
//   in_stb           : sample valid
//   out_i, out_q     : signed window average (floor); updated only with out_stb
//   out_stb          : one-cycle pulse, one clock after each acceptance made with a full window
//   win_full         : WIN samples have been accepted since reset or clear
import dsp_avg_pkg::*;

module win_moving_avg #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LOG2_WIN   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_i,
  input  logic [DATA_WIDTH-1:0] in_q,
  input  logic                  in_stb,
  output logic [DATA_WIDTH-1:0] out_i,
  output logic [DATA_WIDTH-1:0] out_q,
  output logic                  out_stb,
  output logic                  win_full
);

  localparam int unsigned       SW      = sum_width(DATA_WIDTH, LOG2_WIN);
  localparam int unsigned       WIN     = 1 << LOG2_WIN;
  localparam logic [LOG2_WIN:0] WIN_CNT = {1'b1, {LOG2_WIN{1'b0}}};
  localparam logic [LOG2_WIN:0] CNT_ONE = 1;

  if (LOG2_WIN < 1 || LOG2_WIN > MAX_LOG2_WIN) begin : g_bad_win
    $error("win_moving_avg: LOG2_WIN must be in 1..%0d", MAX_LOG2_WIN);
  end

  logic                   accept;
  logic [LOG2_WIN:0]      fill_cnt;
  logic [LOG2_WIN:0]      fill_nxt;
  logic signed [SW-1:0]   sum_i, sum_q;
  logic signed [SW-1:0]   sum_i_nxt, sum_q_nxt;
  logic signed [SW-1:0]   new_i, new_q, old_i, old_q;
  logic [DATA_WIDTH-1:0]  tap_i, tap_q;

  assign accept   = enable & in_stb & ~clear;
  assign win_full = (fill_cnt == WIN_CNT);

  sample_delay_line #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (WIN)
  ) u_delay (
    .clock    (clock),
    .shift_en (accept),
    .din      ({in_i, in_q}),
    .dout     ({tap_i, tap_q})
  );

  // The delay-line tap is subtracted only when the window is full.
  // This masks the stale entries left behind by a reset or a clear.
  always_comb begin
    new_i     = {{LOG2_WIN{in_i[DATA_WIDTH-1]}}, in_i};
    new_q     = {{LOG2_WIN{in_q[DATA_WIDTH-1]}}, in_q};
    old_i     = '0;
    old_q     = '0;
    if (win_full) begin
      old_i = {{LOG2_WIN{tap_i[DATA_WIDTH-1]}}, tap_i};
      old_q = {{LOG2_WIN{tap_q[DATA_WIDTH-1]}}, tap_q};
    end
    sum_i_nxt = sum_i + new_i - old_i;
    sum_q_nxt = sum_q + new_q - old_q;
    fill_nxt  = win_full ? fill_cnt : fill_cnt + CNT_ONE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fill_cnt <= '0;
      sum_i    <= '0;
      sum_q    <= '0;
      out_i    <= '0;
      out_q    <= '0;
      out_stb  <= 1'b0;
    end else begin
      out_stb <= accept && (fill_nxt == WIN_CNT);
      if (enable && clear) begin
        fill_cnt <= '0;
        sum_i    <= '0;
        sum_q    <= '0;
      end else if (accept) begin
        fill_cnt <= fill_nxt;
        sum_i    <= sum_i_nxt;
        sum_q    <= sum_q_nxt;
        if (fill_nxt == WIN_CNT) begin
          // The arithmetic shift gives a floor average from the post-update sum, in the same stage.
          out_i <= DATA_WIDTH'(sum_i_nxt >>> LOG2_WIN);
          out_q <= DATA_WIDTH'(sum_q_nxt >>> LOG2_WIN);
        end
      end
    end
  end

endmodule

// File: tb/tb_win_moving_avg.sv
module tb_win_moving_avg;

  localparam int WIN = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic in_stb = 1'b0;
  logic signed [15:0] in_i = '0;
  logic signed [15:0] in_q = '0;
  logic signed [15:0] out_i, out_q;
  logic out_stb, win_full;

  int checks = 0;
  int failures = 0;

  // Reference model: the samples accepted since the last reset or clear, at most WIN of them.
  int wq_i[$];
  int wq_q[$];
  logic exp_stb = 1'b0;
  logic exp_full = 1'b0;
  logic signed [15:0] exp_i = '0;
  logic signed [15:0] exp_q = '0;

  win_moving_avg #(.DATA_WIDTH(16), .LOG2_WIN(4)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .clear    (clear),
    .in_i     (in_i),
    .in_q     (in_q),
    .in_stb   (in_stb),
    .out_i    (out_i),
    .out_q    (out_q),
    .out_stb  (out_stb),
    .win_full (win_full)
  );

  always #5 clock = ~clock;

  function automatic int floor_div(input int s);
    if (s < 0 && (s % WIN) != 0) return s / WIN - 1;
    return s / WIN;
  endfunction

  function automatic int qsum(input int q[$]);
    int s = 0;
    foreach (q[k]) s += q[k];
    return s;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Drive one cycle of inputs, pass the rising edge, then advance the model.
  task automatic step(input logic en, input logic clr, input logic stb, input int i, input int q);
    enable = en; clear = clr; in_stb = stb;
    in_i = 16'(i); in_q = 16'(q);
    @(posedge clock); #1;
    exp_stb = 1'b0;
    if (en) begin
      if (clr) begin
        wq_i.delete(); wq_q.delete();
      end else if (stb) begin
        wq_i.push_back(int'(in_i)); wq_q.push_back(int'(in_q));
        if (wq_i.size() > WIN) begin
          void'(wq_i.pop_front()); void'(wq_q.pop_front());
        end
        if (wq_i.size() == WIN) begin
          exp_stb = 1'b1;
          exp_i = 16'(floor_div(qsum(wq_i)));
          exp_q = 16'(floor_div(qsum(wq_q)));
        end
      end
    end
    exp_full = (wq_i.size() == WIN);
    clear = 1'b0; in_stb = 1'b0;
  endtask

  task automatic test_reset();
    int pulses, pulse_at;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (out_stb !== 1'b0 || win_full !== 1'b0 || out_i !== 16'sd0 || out_q !== 16'sd0) begin
      failures++;
      $display("FAIL reset_state: got stb=%0b full=%0b i=%0d q=%0d, exp all 0", out_stb, win_full, out_i, out_q);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 1'b1, rnd16(), rnd16());
      checks++;
      if (out_stb !== exp_stb || win_full !== exp_full || out_i !== exp_i || out_q !== exp_q) begin
        failures++;
        $display("FAIL reset_prefill k=%0d: got stb=%0b full=%0b i=%0d q=%0d, exp stb=%0b full=%0b i=%0d q=%0d",
                 k, out_stb, win_full, out_i, out_q, exp_stb, exp_full, exp_i, exp_q);
      end
    end
    #2 reset_n = 1'b0;
    #1;
    wq_i.delete(); wq_q.delete();
    exp_stb = 1'b0; exp_full = 1'b0; exp_i = '0; exp_q = '0;
    checks++;
    if (out_stb !== 1'b0 || win_full !== 1'b0 || out_i !== 16'sd0 || out_q !== 16'sd0) begin
      failures++;
      $display("FAIL reset_async: got stb=%0b full=%0b i=%0d q=%0d, exp all 0", out_stb, win_full, out_i, out_q);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    pulses = 0; pulse_at = -1;
    for (int k = 0; k < 17; k++) begin
      step(1'b1, 1'b0, 1'b1, rnd16(), rnd16());
      if (out_stb === 1'b1) begin pulses++; if (pulse_at < 0) pulse_at = k; end
      checks++;
      if (out_stb !== exp_stb || win_full !== exp_full || out_i !== exp_i || out_q !== exp_q) begin
        failures++;
        $display("FAIL reset_refill k=%0d: got stb=%0b full=%0b i=%0d q=%0d, exp stb=%0b full=%0b i=%0d q=%0d",
                 k, out_stb, win_full, out_i, out_q, exp_stb, exp_full, exp_i, exp_q);
      end
    end
    checks++;
    if (pulses !== 2 || pulse_at !== 15) begin
      failures++;
      $display("FAIL reset_first_stb: got pulses=%0d first=%0d, exp pulses=2 first=15", pulses, pulse_at);
    end
  endtask

  task automatic test_constant();
    step(1'b1, 1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 24; k++) begin
      step(1'b1, 1'b0, 1'b1, 100, -100);
      checks++;
      if (out_stb !== exp_stb || win_full !== exp_full || out_i !== exp_i || out_q !== exp_q) begin
        failures++;
        $display("FAIL constant k=%0d: got stb=%0b full=%0b i=%0d q=%0d, exp stb=%0b full=%0b i=%0d q=%0d",
                 k, out_stb, win_full, out_i, out_q, exp_stb, exp_full, exp_i, exp_q);
      end
      if (k >= 15) begin
        checks++;
        if (out_stb !== 1'b1 || win_full !== 1'b1 || out_i !== 16'sd100 || out_q !== -16'sd100) begin
          failures++;
          $display("FAIL constant_value k=%0d: got stb=%0b full=%0b i=%0d q=%0d, exp 1/1/100/-100",
                   k, out_stb, win_full, out_i, out_q);
        end
      end
    end
  endtask

  task automatic test_step();
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 1'b1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 1'b1, 160, 0);
      checks++;
      if (out_stb !== exp_stb || win_full !== exp_full || out_i !== exp_i || out_q !== exp_q) begin
        failures++;
        $display("FAIL step k=%0d: got stb=%0b full=%0b i=%0d q=%0d, exp stb=%0b full=%0b i=%0d q=%0d",
                 k, out_stb, win_full, out_i, out_q, exp_stb, exp_full, exp_i, exp_q);
      end
      checks++;
      if (int'(out_i) != ((k < 16) ? 10 * (k + 1) : 160)) begin
        failures++;
        $display("FAIL step_ramp k=%0d: got i=%0d, exp %0d", k, out_i, (k < 16) ? 10 * (k + 1) : 160);
      end
    end
  endtask

  task automatic test_gapped();
    int si[20], sq[20];
    int ra_i[$], ra_q[$], rb_i[$], rb_q[$];
    int n, stb_cycles;
    foreach (si[k]) begin si[k] = rnd16(); sq[k] = rnd16(); end
    step(1'b1, 1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 1'b1, si[k], sq[k]);
      if (out_stb === 1'b1) begin ra_i.push_back(int'(out_i)); ra_q.push_back(int'(out_q)); end
    end
    step(1'b1, 1'b1, 1'b0, 0, 0);
    n = 0; stb_cycles = 0;
    for (int c = 0; c < 80 && n < 20; c++) begin
      if (c >= 20 && c < 25) step(1'b0, c[0], 1'b1, 1234, -1234);
      else if (c % 3 == 0) begin step(1'b1, 1'b0, 1'b1, si[n], sq[n]); n++; end
      else step(1'b1, 1'b0, 1'b0, 7, 7);
      if (out_stb === 1'b1) begin
        stb_cycles++; rb_i.push_back(int'(out_i)); rb_q.push_back(int'(out_q));
      end
      checks++;
      if (out_stb !== exp_stb || win_full !== exp_full || out_i !== exp_i || out_q !== exp_q) begin
        failures++;
        $display("FAIL gapped c=%0d: got stb=%0b full=%0b i=%0d q=%0d, exp stb=%0b full=%0b i=%0d q=%0d",
                 c, out_stb, win_full, out_i, out_q, exp_stb, exp_full, exp_i, exp_q);
      end
    end
    checks++;
    if (stb_cycles !== 5 || ra_i.size() !== 5 || ra_i != rb_i || ra_q != rb_q) begin
      failures++;
      $display("FAIL gapped_vs_b2b: got gapped pulses=%0d, b2b pulses=%0d (exp 5 each, equal values)",
               stb_cycles, ra_i.size());
    end
  endtask

  task automatic test_clear();
    step(1'b1, 1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b1, 50, 50);
    step(1'b1, 1'b1, 1'b0, 0, 0);
    checks++;
    if (win_full !== 1'b0 || out_stb !== 1'b0) begin
      failures++;
      $display("FAIL clear_state: got full=%0b stb=%0b, exp 0/0", win_full, out_stb);
    end
    step(1'b1, 1'b1, 1'b1, 30000, 30000);
    for (int k = 0; k < 17; k++) begin
      step(1'b1, 1'b0, 1'b1, rnd16(), rnd16());
      checks++;
      if (out_stb !== exp_stb || win_full !== exp_full || out_i !== exp_i || out_q !== exp_q) begin
        failures++;
        $display("FAIL clear k=%0d: got stb=%0b full=%0b i=%0d q=%0d, exp stb=%0b full=%0b i=%0d q=%0d",
                 k, out_stb, win_full, out_i, out_q, exp_stb, exp_full, exp_i, exp_q);
      end
      checks++;
      if (out_stb !== (k >= 15)) begin
        failures++;
        $display("FAIL clear_delay k=%0d: got stb=%0b, exp %0b", k, out_stb, k >= 15);
      end
    end
  endtask

  task automatic test_extremes();
    int vals[4];
    int want[4];
    vals = '{-32768, 32767, -1, 15};
    want = '{-32768, 32767, -1, 0};
    for (int t = 0; t < 4; t++) begin
      step(1'b1, 1'b1, 1'b0, 0, 0);
      for (int k = 0; k < 16; k++) begin
        if (t < 2 || k == 0) step(1'b1, 1'b0, 1'b1, vals[t], vals[t]);
        else step(1'b1, 1'b0, 1'b1, 0, 0);
        checks++;
        if (out_stb !== exp_stb || win_full !== exp_full || out_i !== exp_i || out_q !== exp_q) begin
          failures++;
          $display("FAIL extreme t=%0d k=%0d: got stb=%0b i=%0d q=%0d, exp stb=%0b i=%0d q=%0d",
                   t, k, out_stb, out_i, out_q, exp_stb, exp_i, exp_q);
        end
      end
      checks++;
      if (int'(out_i) != want[t] || int'(out_q) != want[t] || out_stb !== 1'b1) begin
        failures++;
        $display("FAIL extreme_value t=%0d: got i=%0d q=%0d stb=%0b, exp %0d stb=1",
                 t, out_i, out_q, out_stb, want[t]);
      end
    end
  endtask

  task automatic test_random();
    logic en, clr, stb;
    for (int c = 0; c < 400; c++) begin
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 39) == 0);
      stb = ($urandom_range(0, 9) < 6);
      step(en, clr, stb, rnd16(), rnd16());
      checks++;
      if (out_stb !== exp_stb || win_full !== exp_full || out_i !== exp_i || out_q !== exp_q) begin
        failures++;
        $display("FAIL random c=%0d: got stb=%0b full=%0b i=%0d q=%0d, exp stb=%0b full=%0b i=%0d q=%0d",
                 c, out_stb, win_full, out_i, out_q, exp_stb, exp_full, exp_i, exp_q);
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_step();
    test_gapped();
    test_clear();
    test_extremes();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
